// File: rtl/uart_tx_if.sv
// Byte-producer handshake into the UART transmitter.
// The producer drives valid and data. The transmitter drives ready.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, stop bits, one-entry holding register, frame counter.
// Defining UART_TX_PARITY_EN inserts an even-parity bit and takes one stop bit away, so frame length is unchanged.
module uart_tx #(
  parameter int CLKS_PER_BIT = 9,
  parameter int STOP_BITS    = 2,
  parameter int NUM_PACKETS  = 256,
  localparam int FCW = $clog2(NUM_PACKETS)
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_tx_if.slave       bus,
  output logic           tx,
  output logic           busy,
  output logic           frame_done,
  output logic [FCW-1:0] frame_count,
  output logic           buffer_finish
);
  localparam int CCW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  localparam int STOP_LEN = STOP_BITS - 1;
`else
  localparam int STOP_LEN = STOP_BITS;
`endif
  localparam int BCW = (STOP_LEN > 8) ? $clog2(STOP_LEN) : 3;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_LEN < 1) begin : g_bad_stop
    $error("uart_tx: too few STOP_BITS for this frame format");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t         state, state_n;
  logic [CCW-1:0] clk_cnt, clk_cnt_n;
  logic [BCW-1:0] bit_cnt, bit_cnt_n;
  logic [7:0]     shifter, shifter_n;
  logic [7:0]     hold_q, hold_n;
  logic           hold_full, hold_full_n;
  logic           tx_n;
  logic           load;
  logic [7:0]     load_val;
  logic           accept, bit_end, stop_last, fc_wrap;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_n;
`endif

  assign bus.tx_ready  = !hold_full;
  assign accept        = bus.tx_valid && !hold_full;
  assign bit_end       = (clk_cnt == CCW'(CLKS_PER_BIT - 1));
  assign stop_last     = (bit_cnt == BCW'(STOP_LEN - 1));
  assign frame_done    = (state == STOP) && bit_end && stop_last;
  assign fc_wrap       = (frame_count == FCW'(NUM_PACKETS - 1));
  assign buffer_finish = frame_done && fc_wrap;
  assign busy          = (state != IDLE) || hold_full;

  always_comb begin
    state_n     = state;
    clk_cnt_n   = bit_end ? '0 : clk_cnt + 1'b1;
    bit_cnt_n   = bit_cnt;
    shifter_n   = shifter;
    hold_n      = hold_q;
    hold_full_n = hold_full;
    load        = 1'b0;
    load_val    = bus.tx_data;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_cnt_n = '0;
        // A byte left in the holding register by a late accept goes out after one idle cycle.
        if (hold_full) begin
          load        = 1'b1;
          load_val    = hold_q;
          hold_full_n = 1'b0;
          state_n     = START;
        end else if (accept) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shifter_n = {1'b0, shifter[7:1]};
        if (bit_cnt == BCW'(7)) begin
          bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
          state_n   = PARITY;
`else
          state_n   = STOP;
`endif
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: if (bit_end) begin
        if (stop_last) begin
          bit_cnt_n = '0;
          if (hold_full) begin
            load        = 1'b1;
            load_val    = hold_q;
            hold_full_n = 1'b0;
            state_n     = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (accept && state != IDLE) begin
      hold_n      = bus.tx_data;
      hold_full_n = 1'b1;
    end
    if (load) shifter_n = load_val;
  end

`ifdef UART_TX_PARITY_EN
  assign par_n = load ? ^load_val : par_q;
`endif

  // The line level is computed from the next state, so tx itself is a plain flop.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shifter_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shifter     <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      tx          <= 1'b1;
      frame_count <= '0;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shifter   <= shifter_n;
      hold_q    <= hold_n;
      hold_full <= hold_full_n;
      tx        <= tx_n;
      if (frame_done) frame_count <= fc_wrap ? '0 : frame_count + 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) par_q <= 1'b0;
    else        par_q <= par_n;
  end
`endif
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: single frames, back-to-back, hold stall, mid-frame reset, counter wrap.
module tb_uart_tx;
  localparam int CPB = 9;
  localparam int NP  = 256;
  // Transmitted bit k of a frame is bit k of these constants (bit 0 = start bit).
`ifdef UART_TX_PARITY_EN
  localparam logic [10:0] FR_A5 = 11'b101_0100_1010;
  localparam logic [10:0] FR_00 = 11'b100_0000_0000;
  localparam logic [10:0] FR_FF = 11'b101_1111_1110;
  localparam logic [10:0] FR_11 = 11'b100_0010_0010;
  localparam logic [10:0] FR_22 = 11'b100_0100_0100;
  localparam logic [10:0] FR_3C = 11'b100_0111_1000;
  localparam logic [10:0] FR_81 = 11'b101_0000_0010;
`else
  localparam logic [10:0] FR_A5 = 11'b111_0100_1010;
  localparam logic [10:0] FR_00 = 11'b110_0000_0000;
  localparam logic [10:0] FR_FF = 11'b111_1111_1110;
  localparam logic [10:0] FR_11 = 11'b110_0010_0010;
  localparam logic [10:0] FR_22 = 11'b110_0100_0100;
  localparam logic [10:0] FR_3C = 11'b110_0111_1000;
  localparam logic [10:0] FR_81 = 11'b111_0000_0010;
`endif
  localparam logic [10:0] FR_07 = 11'b110_0000_1110;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx, busy, frame_done, buffer_finish;
  logic [7:0] frame_count;
  int         errors = 0;
  int         checks = 0;

  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .NUM_PACKETS(NP)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus), .tx(tx), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .buffer_finish(buffer_finish)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    n_rst = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if ({tx, bus.tx_ready, busy, frame_done, buffer_finish} !== 5'b11000) begin
      errors++; $display("FAIL rst_outs: got %b want 11000", {tx, bus.tx_ready, busy, frame_done, buffer_finish}); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", frame_count); end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({tx, bus.tx_ready, busy, frame_done, buffer_finish} !== 5'b11000) begin
      errors++; $display("FAIL idle_outs: got %b want 11000", {tx, bus.tx_ready, busy, frame_done, buffer_finish}); end
  endtask

  task automatic test_single_frame(input string nm, input logic [7:0] b, input logic [10:0] e, input int fc_exp);
    int fd_n, fd_cyc;
    fd_n = 0; fd_cyc = 0;
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = b;
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      checks++; if (tx !== ((c <= 99) ? e[(c-1)/CPB] : 1'b1)) begin
        errors++; $display("FAIL %s_tx cyc %0d: got %b want %b", nm, c, tx, (c <= 99) ? e[(c-1)/CPB] : 1'b1); end
      checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL %s_ready cyc %0d: got %b want 1", nm, c, bus.tx_ready); end
      if (frame_done === 1'b1) begin fd_n++; fd_cyc = c; end
    end
    checks++; if (fd_n !== 1) begin errors++; $display("FAIL %s_fd_count: got %0d want 1", nm, fd_n); end
    checks++; if (fd_cyc !== 99) begin errors++; $display("FAIL %s_fd_cycle: got %0d want 99", nm, fd_cyc); end
    checks++; if (frame_count !== 8'(fc_exp)) begin errors++; $display("FAIL %s_count: got %0d want %0d", nm, frame_count, fc_exp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b want 0", nm, busy); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e;
    int fd_n;
    int fd_cyc [2];
    logic rdy_exp;
    e = {FR_FF, FR_00}; fd_n = 0; fd_cyc[0] = 0; fd_cyc[1] = 0;
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'h00;
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      checks++; if (tx !== ((c <= 198) ? e[(c-1)/CPB] : 1'b1)) begin
        errors++; $display("FAIL b2b_tx cyc %0d: got %b want %b", c, tx, (c <= 198) ? e[(c-1)/CPB] : 1'b1); end
      rdy_exp = (c <= 2 || c >= 100);
      checks++; if (bus.tx_ready !== rdy_exp) begin errors++; $display("FAIL b2b_ready cyc %0d: got %b want %b", c, bus.tx_ready, rdy_exp); end
      if (frame_done === 1'b1) begin if (fd_n < 2) fd_cyc[fd_n] = c; fd_n++; end
      bus.tx_valid = (c == 2); bus.tx_data = 8'hFF;
    end
    checks++; if (fd_n !== 2) begin errors++; $display("FAIL b2b_fd_count: got %0d want 2", fd_n); end
    checks++; if (fd_cyc[0] !== 99) begin errors++; $display("FAIL b2b_fd0: got %0d want 99", fd_cyc[0]); end
    checks++; if (fd_cyc[1] !== 198) begin errors++; $display("FAIL b2b_fd1: got %0d want 198", fd_cyc[1]); end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", frame_count); end
  endtask

  task automatic test_hold_valid();
    logic [32:0] e;
    int fd_n, n22, n3c, acc3c;
    int fd_cyc [3];
    logic rdy_q;
    e = {FR_3C, FR_22, FR_11}; fd_n = 0; n22 = 0; n3c = 0; acc3c = 0; rdy_q = 1'b0;
    for (int i = 0; i < 3; i++) fd_cyc[i] = 0;
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'h11;
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.tx_valid && rdy_q) begin
        if (bus.tx_data == 8'h22) n22++;
        if (bus.tx_data == 8'h3C) begin n3c++; acc3c = c; end
      end
      checks++; if (tx !== ((c <= 297) ? e[(c-1)/CPB] : 1'b1)) begin
        errors++; $display("FAIL hold_tx cyc %0d: got %b want %b", c, tx, (c <= 297) ? e[(c-1)/CPB] : 1'b1); end
      if (c >= 2 && c <= 99) begin
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL hold_ready cyc %0d: got %b want 0", c, bus.tx_ready); end
      end
      if (frame_done === 1'b1) begin if (fd_n < 3) fd_cyc[fd_n] = c; fd_n++; end
      if (c == 1) begin bus.tx_valid = 1'b1; bus.tx_data = 8'h22; end
      else if (n3c == 0) begin bus.tx_valid = 1'b1; bus.tx_data = 8'h3C; end
      else bus.tx_valid = 1'b0;
      rdy_q = bus.tx_ready;
    end
    bus.tx_valid = 1'b0;
    checks++; if (n22 !== 1) begin errors++; $display("FAIL hold_n22: got %0d want 1", n22); end
    checks++; if (n3c !== 1) begin errors++; $display("FAIL hold_n3c: got %0d want 1", n3c); end
    checks++; if (acc3c !== 101) begin errors++; $display("FAIL hold_acc3c: got %0d want 101", acc3c); end
    checks++; if (fd_n !== 3) begin errors++; $display("FAIL hold_fd_count: got %0d want 3", fd_n); end
    checks++; if (fd_cyc[0] !== 99 || fd_cyc[1] !== 198 || fd_cyc[2] !== 297) begin
      errors++; $display("FAIL hold_fd_cycles: got %0d/%0d/%0d want 99/198/297", fd_cyc[0], fd_cyc[1], fd_cyc[2]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'h55;
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    repeat (48) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    n_rst = 1'b0;
    #1;
    checks++; if ({tx, bus.tx_ready, busy, frame_done, buffer_finish} !== 5'b11000) begin
      errors++; $display("FAIL mid_rst_outs: got %b want 11000", {tx, bus.tx_ready, busy, frame_done, buffer_finish}); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", frame_count); end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      checks++; if ({tx, frame_done} !== 2'b10) begin errors++; $display("FAIL mid_quiet cyc %0d: got tx,fd=%b want 10", c, {tx, frame_done}); end
    end
  endtask

  task automatic test_wrap();
    int acc, nfd, nbf, bf_at;
    acc = 0; nfd = 0; nbf = 0; bf_at = 0;
    @(negedge clk); n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    for (int c = 0; c < 30000 && nfd < NP; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        nfd++;
        checks++; if (frame_count !== 8'(nfd - 1)) begin errors++; $display("FAIL wrap_count frame %0d: got %0d want %0d", nfd, frame_count, 8'(nfd - 1)); end
      end
      if (buffer_finish === 1'b1) begin nbf++; bf_at = nfd; end
      bus.tx_valid = (acc < NP) && bus.tx_ready;
      if (bus.tx_valid) begin bus.tx_data = 8'(acc); acc++; end
    end
    bus.tx_valid = 1'b0;
    checks++; if (nfd !== NP) begin errors++; $display("FAIL wrap_frames: got %0d want %0d", nfd, NP); end
    checks++; if (nbf !== 1) begin errors++; $display("FAIL wrap_bf_count: got %0d want 1", nbf); end
    checks++; if (bf_at !== NP) begin errors++; $display("FAIL wrap_bf_frame: got %0d want %0d", bf_at, NP); end
    @(negedge clk);
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_count_final: got %0d want 0", frame_count); end
    checks++; if (buffer_finish !== 1'b0) begin errors++; $display("FAIL wrap_bf_after: got %b want 0", buffer_finish); end
  endtask

  initial begin
    test_reset();
    test_single_frame("a5", 8'hA5, FR_A5, 1);
    test_back_to_back();
    test_hold_valid();
    test_reset_mid_frame();
    test_single_frame("81", 8'h81, FR_81, 1);
    test_single_frame("07", 8'h07, FR_07, 2);
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
